// File: rtl/hazard3_debug_entry.sv
// Debug-mode entry/exit sequencer: arbitrates halt causes, owns dpc and dcsr.cause.
// Define HAZARD3_DEBUG_STEP_EN to build the single-step logic.
module hazard3_debug_entry #(
    parameter int unsigned W_ADDR = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig_break_any,
    input  logic              trig_break_d_mode,
    input  logic              ebreak_d,
    input  logic              dbg_req_halt,
    input  logic              dbg_req_resume,
    input  logic              dcsr_step,
    input  logic              instr_retire,
    input  logic [W_ADDR-1:0] pc,
    input  logic [W_ADDR-1:0] pc_next,
    input  logic              x_ready,
    input  logic              dpc_wen,
    input  logic [W_ADDR-1:0] dpc_wdata,
    output logic              m_trap_req,
    output logic              d_entry_req,
    output logic              resume_req,
    output logic [W_ADDR-1:0] resume_pc,
    output logic              d_mode,
    output logic              dbg_halted,
    output logic              dbg_resumeack,
    output logic [W_ADDR-1:0] dpc,
    output logic [2:0]        dcsr_cause
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_PEND   = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;
    localparam logic [1:0] S_RESUME = 2'd3;

    localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
    localparam logic [2:0] CAUSE_TRIGGER = 3'd2;
    localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
    localparam logic [2:0] CAUSE_STEP    = 3'd4;

    logic [1:0]        state_q, state_d;
    logic [W_ADDR-1:0] dpc_q, dpc_d;
    logic [2:0]        cause_q, cause_d;
    logic              resumeack_q, resumeack_d;

    logic              in_run;
    logic              trig_d_cause;
    logic              step_cause;
    logic              any_d_cause;
    logic [W_ADDR-1:0] step_pc;

    assign in_run       = (state_q == S_RUN);
    assign trig_d_cause = in_run && trig_break_any && trig_break_d_mode;
    assign any_d_cause  = in_run && (trig_d_cause || ebreak_d || dbg_req_halt || step_cause);

`ifdef HAZARD3_DEBUG_STEP_EN
    logic step_pend_q, step_pend_d;

    assign step_cause = in_run && step_pend_q && instr_retire;
    assign step_pc    = pc_next;

    // Armed on the way out of Debug mode; any cause taken in RUN disarms it.
    always_comb begin
        step_pend_d = step_pend_q;
        if (state_q == S_RESUME && x_ready) begin
            step_pend_d = dcsr_step;
        end else if (in_run && (instr_retire || any_d_cause)) begin
            step_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_pend_q <= 1'b0;
        end else begin
            step_pend_q <= step_pend_d;
        end
    end
`else
    logic unused_step;

    assign step_cause  = 1'b0;
    assign step_pc     = pc;
    assign unused_step = ^{dcsr_step, instr_retire, pc_next};
`endif

    // Redirect handshake: d_entry_req / resume_req are the valid, held high
    // and stable until the X stage asserts x_ready; the transfer completes
    // on the clock edge where both are high.
    always_comb begin
        state_d     = state_q;
        dpc_d       = dpc_q;
        cause_d     = cause_q;
        resumeack_d = 1'b0;
        case (state_q)
            S_RUN: begin
                if (any_d_cause) begin
                    state_d = S_PEND;
                    dpc_d   = pc;
                    if (trig_d_cause) begin
                        cause_d = CAUSE_TRIGGER;
                    end else if (ebreak_d) begin
                        cause_d = CAUSE_EBREAK;
                    end else if (dbg_req_halt) begin
                        cause_d = CAUSE_HALTREQ;
                    end else begin
                        cause_d = CAUSE_STEP;
                        dpc_d   = step_pc;
                    end
                end
            end
            S_PEND: begin
                if (x_ready) begin
                    state_d = S_HALTED;
                end
            end
            S_HALTED: begin
                if (dpc_wen) begin
                    dpc_d = dpc_wdata;
                end
                if (dbg_req_resume) begin
                    state_d = S_RESUME;
                end
            end
            S_RESUME: begin
                if (x_ready) begin
                    state_d     = S_RUN;
                    resumeack_d = 1'b1;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            dpc_q       <= '0;
            cause_q     <= 3'd0;
            resumeack_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dpc_q       <= dpc_d;
            cause_q     <= cause_d;
            resumeack_q <= resumeack_d;
        end
    end

    assign m_trap_req    = in_run && trig_break_any && !trig_break_d_mode && !any_d_cause;
    assign d_entry_req   = (state_q == S_PEND);
    assign resume_req    = (state_q == S_RESUME);
    assign d_mode        = (state_q == S_HALTED) || (state_q == S_RESUME);
    assign dbg_halted    = (state_q == S_HALTED);
    assign dbg_resumeack = resumeack_q;
    assign dpc           = dpc_q;
    assign resume_pc     = dpc_q;
    assign dcsr_cause    = cause_q;

endmodule
